// File: rtl/sr_rx_ctrl_pkg.sv
// Shared types and timing helpers for the sr_rx_ctrl serial receive controller.
package sr_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    PARITY,
    STOP
  } state_t;

  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

  function automatic int unsigned timer_w(input int unsigned clks_per_bit);
    return $clog2(clks_per_bit + 1);
  endfunction

endpackage

// File: rtl/sr_rx_ctrl_bit_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module bit_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/sr_rx_ctrl.sv
// Frame sequencer for an LSB-first serial-to-parallel shift register.
// Optional even-parity bit enabled with `define SR_RX_PARITY_EN.
module sr_rx_ctrl
  import sr_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic [DATA_BITS-1:0] parallel_in,
  output logic                 shift_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 framing_err,
  output logic                 overrun_err
`ifdef SR_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned HB = half_bit(CLKS_PER_BIT);
  localparam int unsigned TW = timer_w(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  // Timer expires when the count reaches zero, so loads are one short.
  localparam logic [TW-1:0] LD_HALF  = TW'(HB - 1);
  localparam logic [TW-1:0] LD_BIT   = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_tc;
  logic                   w_load;
  logic [TW-1:0]          w_load_val;
  logic                   w_shift;
  logic [BW-1:0]          r_bit_cnt;
  logic                   r_line;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_oerr;
`ifdef SR_RX_PARITY_EN
  logic                   r_par;
  logic                   r_perr;
`endif

  bit_timer #(
    .W(TW)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_tc       (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = LD_BIT;
    w_shift    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!serial_in && r_line) begin
          w_next     = START_CHK;
          w_load     = 1'b1;
          w_load_val = LD_HALF;
        end
      end
      START_CHK: begin
        if (w_tc) begin
          if (serial_in) begin
            w_next = IDLE;
          end else begin
            w_next = DATA;
            w_load = 1'b1;
          end
        end
      end
      DATA: begin
        if (w_tc) begin
          w_shift = 1'b1;
          w_load  = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
`ifdef SR_RX_PARITY_EN
            w_next = PARITY;
`else
            w_next = STOP;
`endif
          end
        end
      end
`ifdef SR_RX_PARITY_EN
      PARITY: begin
        if (w_tc) begin
          w_next = STOP;
          w_load = 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_tc) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Word handoff: error priority is framing, then parity, then overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_line    <= 1'b1;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
`ifdef SR_RX_PARITY_EN
      r_par     <= 1'b0;
      r_perr    <= 1'b0;
`endif
    end else begin
      r_line <= serial_in;
      r_ferr <= 1'b0;
      r_oerr <= 1'b0;
`ifdef SR_RX_PARITY_EN
      r_perr <= 1'b0;
      if (r_state == PARITY && w_tc) r_par <= serial_in;
`endif
      if (r_state == IDLE)  r_bit_cnt <= '0;
      else if (w_shift)     r_bit_cnt <= r_bit_cnt + BW'(1);

      if (r_valid && rx_ready) r_valid <= 1'b0;

      if (r_state == STOP && w_tc) begin
        if (!serial_in) begin
          r_ferr <= 1'b1;
`ifdef SR_RX_PARITY_EN
        end else if ((^parallel_in) != r_par) begin
          r_perr <= 1'b1;
`endif
        end else if (r_valid && !rx_ready) begin
          r_oerr <= 1'b1;
        end else begin
          r_data  <= parallel_in;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign shift_enable = w_shift;
  assign busy         = (r_state != IDLE);
  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign framing_err  = r_ferr;
  assign overrun_err  = r_oerr;
`ifdef SR_RX_PARITY_EN
  assign parity_err   = r_perr;
`endif

endmodule

// File: tb/tb_sr_rx_ctrl.sv
// Randomized self-checking bench for sr_rx_ctrl against a frame-level reference model.
module tb_sr_rx_ctrl;

  localparam int unsigned DB  = 8;
  localparam int unsigned CPB = 10;
  localparam int unsigned HB  = CPB / 2;
`ifdef SR_RX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif
  localparam int unsigned STOP_R    = HB + (DB + 1 + P) * CPB;
  localparam int unsigned FRAME_LEN = (DB + 2 + P) * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          serial_in = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] sr = '0;
  logic [DB-1:0] rx_data;
  logic          shift_enable, rx_valid, busy, framing_err, overrun_err;
`ifdef SR_RX_PARITY_EN
  logic          parity_err;
`endif
  logic          se_lat = 1'b0;
  logic          si_lat = 1'b1;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          m_valid = 1'b0;
  logic [DB-1:0] m_data  = '0;

  sr_rx_ctrl #(
    .DATA_BITS    (DB),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .parallel_in  (sr),
    .shift_enable (shift_enable),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .busy         (busy),
    .framing_err  (framing_err),
    .overrun_err  (overrun_err)
`ifdef SR_RX_PARITY_EN
    ,
    .parity_err   (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Shift register beside the controller: LSB first, new bit enters at the MSB.
  always @(negedge clk) begin
    se_lat <= shift_enable;
    si_lat <= serial_in;
  end
  always @(posedge clk) if (se_lat) sr <= {si_lat, sr[DB-1:1]};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line_bit(input logic [DB-1:0] d, input logic stop_b,
                                    input logic par_b, input int unsigned r);
    int unsigned idx;
    idx = r / CPB;
    if (idx == 0)                        return 1'b0;
    else if (idx <= DB)                  return d[idx-1];
    else if (P == 1 && idx == DB + 1)    return par_b;
    else if (idx == DB + 1 + P)          return stop_b;
    else                                 return 1'b1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b,
                            input int unsigned mode, input int unsigned gap);
    int unsigned shifts[$];
    int          nf, no, np, kind;
    nf = 0; no = 0; np = 0; kind = 0;
    for (int unsigned r = 0; r < FRAME_LEN + gap; r++) begin
      serial_in = line_bit(d, stop_b, par_b, r);
      rx_ready  = (mode == 1) || (mode == 2 && r == STOP_R);
      @(negedge clk);
      if (shift_enable) shifts.push_back(r);
      nf += int'(framing_err);
      no += int'(overrun_err);
`ifdef SR_RX_PARITY_EN
      np += int'(parity_err);
`endif
      if (r == STOP_R) begin
        check("busy_at_stop", 32'(busy), 32'(1));
        if (!stop_b)                               kind = 1;
        else if (P == 1 && par_b != (^d))          kind = 2;
        else if (m_valid && !rx_ready)             kind = 3;
        else                                       kind = 0;
        if (kind == 0) begin
          m_valid = 1'b1;
          m_data  = d;
        end else if (rx_ready && m_valid) begin
          m_valid = 1'b0;
        end
      end else begin
        if (r == STOP_R + 1) begin
          check("busy_after_stop", 32'(busy), 32'(0));
          check("framing_err_pulse", 32'(framing_err), 32'(kind == 1));
          check("overrun_err_pulse", 32'(overrun_err), 32'(kind == 3));
`ifdef SR_RX_PARITY_EN
          check("parity_err_pulse", 32'(parity_err), 32'(kind == 2));
`endif
          check("rx_valid_done", 32'(rx_valid), 32'(m_valid));
          if (m_valid) check("rx_data_done", 32'(rx_data), 32'(m_data));
        end
        if (rx_ready && m_valid) m_valid = 1'b0;
      end
      next_cycle();
    end
    rx_ready = 1'b0;
    check("shift_count", 32'(shifts.size()), 32'(DB));
    for (int k = 0; k < shifts.size(); k++)
      check("shift_time", shifts[k], HB + (k + 1) * CPB);
    check("framing_err_count", 32'(nf), 32'(kind == 1));
    check("overrun_err_count", 32'(no), 32'(kind == 3));
`ifdef SR_RX_PARITY_EN
    check("parity_err_count", 32'(np), 32'(kind == 2));
`endif
    @(negedge clk);
    check("rx_valid_end", 32'(rx_valid), 32'(m_valid));
    if (m_valid) check("rx_data_hold", 32'(rx_data), 32'(m_data));
    next_cycle();
  endtask

  task automatic false_start();
    int ns, ne;
    ns = 0; ne = 0;
    rx_ready = 1'b0;
    for (int unsigned r = 0; r < HB + 4; r++) begin
      serial_in = (r < 2) ? 1'b0 : 1'b1;
      @(negedge clk);
      ns += int'(shift_enable);
      ne += int'(framing_err) + int'(overrun_err);
      if (r == HB)     check("false_start_busy", 32'(busy), 32'(1));
      if (r == HB + 1) check("false_start_idle", 32'(busy), 32'(0));
      next_cycle();
    end
    check("false_start_shifts", 32'(ns), 32'(0));
    check("false_start_errs", 32'(ne), 32'(0));
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    @(negedge clk);
    check("accept_valid", 32'(rx_valid), 32'(m_valid));
    if (m_valid) check("accept_data", 32'(rx_data), 32'(m_data));
    m_valid = 1'b0;
    next_cycle();
    rx_ready = 1'b0;
    @(negedge clk);
    check("accept_cleared", 32'(rx_valid), 32'(0));
    next_cycle();
  endtask

  task automatic reset_mid(input logic [DB-1:0] d);
    rx_ready = 1'b0;
    for (int unsigned r = 0; r <= 40; r++) begin
      serial_in = line_bit(d, 1'b1, ^d, r);
      rst       = (r == 40);
      next_cycle();
    end
    rst       = 1'b0;
    serial_in = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_shift", 32'(shift_enable), 32'(0));
    check("rstmid_valid", 32'(rx_valid), 32'(0));
    check("rstmid_data", 32'(rx_data), 32'(0));
    m_valid = 1'b0;
    m_data  = '0;
    next_cycle();
    idle(20);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop_b, par_b;
    rst = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_valid", 32'(rx_valid), 32'(0));
    check("reset_data", 32'(rx_data), 32'(0));
    check("reset_shift", 32'(shift_enable), 32'(0));
    check("reset_ferr", 32'(framing_err), 32'(0));
    check("reset_oerr", 32'(overrun_err), 32'(0));
    next_cycle();
    rst = 1'b0;
    idle(3);

    send_frame(8'hA5, 1'b1, ^8'hA5, 1, 5);
    false_start();
    idle(2);
    send_frame(8'h3C, 1'b0, ^8'h3C, 1, 5);
    send_frame(8'h81, 1'b1, ^8'h81, 1, 5);
    send_frame(8'h11, 1'b1, ^8'h11, 0, 3);
    send_frame(8'h22, 1'b1, ^8'h22, 0, 3);
    accept();
    idle(2);
    reset_mid(8'h5A);
    send_frame(8'h5A, 1'b1, ^8'h5A, 1, 5);
`ifdef SR_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0, 1, 5);
    send_frame(8'h07, 1'b1, 1'b1, 1, 5);
`endif

    for (int i = 0; i < 25; i++) begin
      d      = DB'($urandom);
      stop_b = ($urandom_range(0, 3) != 0);
      par_b  = ($urandom_range(0, 3) != 0) ? ^d : ~(^d);
      if ($urandom_range(0, 5) == 0) begin
        false_start();
        idle(2);
      end
      send_frame(d, stop_b, par_b, $urandom_range(0, 2), $urandom_range(2, 6));
      if ($urandom_range(0, 3) == 0) accept();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
